// File: rtl/pacman_sound.sv
// Square-wave melody player for the game's sound_type: a fixed 4-note tune per sound on a single PWM pin.
// Optional PACMAN_SOUND_VOLUME_EN adds a 3-bit volume input that duty-gates the square wave.
package pacman_sound_pkg;
  typedef enum logic [2:0] {
    SOUND_LOADING   = 3'd0,
    SOUND_READY     = 3'd1,
    SOUND_GAME_PLAY = 3'd2,
    SOUND_FAIL      = 3'd3,
    SOUND_WIN       = 3'd4
  } sound_t;
endpackage

module pacman_sound
  import pacman_sound_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ_HZ = 25_000_000,
  parameter int unsigned TICK_MS       = 50
) (
  input  logic       vga_pix_clk,
  input  logic       rst,
  input  sound_t     sound_type,
`ifdef PACMAN_SOUND_VOLUME_EN
  input  logic [2:0] volume,
`endif
  output logic       audio_pwm,
  output logic       audio_sd,
  output logic       busy
);

  localparam int unsigned TICK_CLKS = CLOCK_FREQ_HZ / 1000 * TICK_MS;
  localparam int unsigned PRE_W     = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
  localparam int unsigned HALF_MAX  = CLOCK_FREQ_HZ / (2 * 523);
  localparam int unsigned TONE_W    = $clog2(HALF_MAX + 1);

  // Half-period reload values (HALF-1) per pitch index, fixed at elaboration.
  localparam logic [TONE_W-1:0] HM1_1 = TONE_W'(CLOCK_FREQ_HZ / (2 * 523) - 1);
  localparam logic [TONE_W-1:0] HM1_2 = TONE_W'(CLOCK_FREQ_HZ / (2 * 587) - 1);
  localparam logic [TONE_W-1:0] HM1_3 = TONE_W'(CLOCK_FREQ_HZ / (2 * 659) - 1);
  localparam logic [TONE_W-1:0] HM1_4 = TONE_W'(CLOCK_FREQ_HZ / (2 * 698) - 1);
  localparam logic [TONE_W-1:0] HM1_5 = TONE_W'(CLOCK_FREQ_HZ / (2 * 784) - 1);
  localparam logic [TONE_W-1:0] HM1_6 = TONE_W'(CLOCK_FREQ_HZ / (2 * 880) - 1);
  localparam logic [TONE_W-1:0] HM1_7 = TONE_W'(CLOCK_FREQ_HZ / (2 * 988) - 1);
  localparam logic [TONE_W-1:0] HM1_8 = TONE_W'(CLOCK_FREQ_HZ / (2 * 1047) - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_PLAY, S_DONE} state_t;

  typedef struct packed {
    logic [3:0] pitch;
    logic [3:0] dur;
  } note_t;

  function automatic logic [TONE_W-1:0] reload_of(input logic [3:0] p);
    logic [TONE_W-1:0] r;
    case (p)
      4'd1:    r = HM1_1;
      4'd2:    r = HM1_2;
      4'd3:    r = HM1_3;
      4'd4:    r = HM1_4;
      4'd5:    r = HM1_5;
      4'd6:    r = HM1_6;
      4'd7:    r = HM1_7;
      4'd8:    r = HM1_8;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic note_t note_of(input sound_t t, input logic [1:0] idx);
    note_t n;
    n = '{pitch: 4'd0, dur: 4'd1};
    case (t)
      SOUND_LOADING:
        case (idx)
          2'd0: n = '{4'd1, 4'd2};
          2'd1: n = '{4'd3, 4'd2};
          2'd2: n = '{4'd5, 4'd2};
          default: n = '{4'd0, 4'd2};
        endcase
      SOUND_READY:
        case (idx)
          2'd0: n = '{4'd5, 4'd4};
          2'd1: n = '{4'd6, 4'd4};
          2'd2: n = '{4'd8, 4'd8};
          default: n = '{4'd0, 4'd1};
        endcase
      SOUND_GAME_PLAY:
        case (idx)
          2'd0: n = '{4'd1, 4'd1};
          2'd1: n = '{4'd0, 4'd1};
          2'd2: n = '{4'd5, 4'd1};
          default: n = '{4'd0, 4'd1};
        endcase
      SOUND_FAIL:
        case (idx)
          2'd0: n = '{4'd8, 4'd4};
          2'd1: n = '{4'd6, 4'd4};
          2'd2: n = '{4'd4, 4'd4};
          default: n = '{4'd1, 4'd8};
        endcase
      SOUND_WIN:
        case (idx)
          2'd0: n = '{4'd1, 4'd2};
          2'd1: n = '{4'd3, 4'd2};
          2'd2: n = '{4'd5, 4'd2};
          default: n = '{4'd8, 4'd8};
        endcase
      default: n = '{4'd0, 4'd1};
    endcase
    return n;
  endfunction

  function automatic logic is_loop(input sound_t t);
    return (t == SOUND_LOADING) || (t == SOUND_GAME_PLAY);
  endfunction

  function automatic logic is_known(input sound_t t);
    logic k;
    case (t)
      SOUND_LOADING, SOUND_READY, SOUND_GAME_PLAY, SOUND_FAIL, SOUND_WIN: k = 1'b1;
      default: k = 1'b0;
    endcase
    return k;
  endfunction

  state_t            state, next_state;
  sound_t            cur_type;
  logic [1:0]        note_idx;
  logic [TONE_W-1:0] tone_cnt;
  logic              sq;
  logic [PRE_W-1:0]  presc;
  logic [3:0]        tick_cnt;
  logic              vol_gate;
  note_t             cur_note, nxt_note;
  logic              note_end;

  assign cur_note = note_of(cur_type, note_idx);
  assign nxt_note = note_of(cur_type, note_idx + 2'd1);
  assign note_end = (state == S_PLAY) && (presc == PRE_W'(TICK_CLKS - 1)) &&
                    (tick_cnt == cur_note.dur - 4'd1);

  always_ff @(posedge vga_pix_clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cur_type <= SOUND_LOADING;
    end else begin
      state    <= next_state;
      cur_type <= sound_type;
    end
  end

  // A type change (or leaving reset) restarts the melody and outranks any note advance.
  always_comb begin
    next_state = state;
    if ((sound_type != cur_type) || (state == S_IDLE)) begin
      next_state = S_START;
    end else begin
      case (state)
        S_START: next_state = is_known(cur_type) ? S_PLAY : S_DONE;
        S_PLAY:
          if (note_end && (note_idx == 2'd3) && !is_loop(cur_type)) next_state = S_DONE;
        default: next_state = state;
      endcase
    end
  end

  // The first note of a melody starts with sq high; later notes start low after the clear.
  always_ff @(posedge vga_pix_clk) begin
    if (rst || (next_state == S_START)) begin
      note_idx <= '0;
      tone_cnt <= '0;
      sq       <= 1'b0;
      presc    <= '0;
      tick_cnt <= '0;
    end else if (state == S_START) begin
      tone_cnt <= reload_of(cur_note.pitch);
      sq       <= (cur_note.pitch != 4'd0);
    end else if (state == S_PLAY) begin
      if (note_end) begin
        note_idx <= note_idx + 2'd1;
        presc    <= '0;
        tick_cnt <= '0;
        sq       <= 1'b0;
        tone_cnt <= reload_of(nxt_note.pitch);
      end else begin
        if (presc == PRE_W'(TICK_CLKS - 1)) begin
          presc    <= '0;
          tick_cnt <= tick_cnt + 4'd1;
        end else begin
          presc <= presc + 1'b1;
        end
        if (cur_note.pitch == 4'd0) begin
          sq       <= 1'b0;
          tone_cnt <= '0;
        end else if (tone_cnt == '0) begin
          sq       <= ~sq;
          tone_cnt <= reload_of(cur_note.pitch);
        end else begin
          tone_cnt <= tone_cnt - 1'b1;
        end
      end
    end
  end

`ifdef PACMAN_SOUND_VOLUME_EN
  logic [2:0] pwm_cnt;

  always_ff @(posedge vga_pix_clk) begin
    if (rst) pwm_cnt <= '0;
    else     pwm_cnt <= pwm_cnt + 3'd1;
  end

  assign vol_gate = (pwm_cnt < volume);
`else
  assign vol_gate = 1'b1;
`endif

  always_comb begin
    busy      = (state == S_START) || (state == S_PLAY);
    audio_sd  = (state == S_START) || (state == S_PLAY);
    audio_pwm = (state == S_PLAY) && sq && vol_gate;
  end

endmodule

// File: doc/pacman_sound.md
Name: pacman_sound

Overview:
- Downstream audio stage for the game core; consumes its registered `sound_type` enum.
- Plays a fixed 4-note square-wave melody for each sound type through a mono PWM/speaker pin.
- Restarts the melody whenever `sound_type` changes.
- Runs on the VGA pixel clock, so no clock-domain crossing is needed.

Parameters:
- CLOCK_FREQ_HZ, 25_000_000, frequency of vga_pix_clk in Hz.
- TICK_MS, 50, duration unit in ms; TICK_CLKS = CLOCK_FREQ_HZ/1000*TICK_MS (integer division).

Ports:
- vga_pix_clk, input, 1, sole clock; all logic on its rising edge.
- rst, input, 1, synchronous active-high reset.
- sound_type, input, sound_t, requested sound (SOUND_LOADING/READY/GAME_PLAY/FAIL/WIN).
- audio_pwm, output, 1, square-wave audio.
- audio_sd, output, 1, amplifier enable; 1 while a note or rest is in progress.
- busy, output, 1, melody active.

Behaviour:
- Pitch table, index -> Hz: 0=rest, 1=523, 2=587, 3=659, 4=698, 5=784, 6=880, 7=988, 8=1047.
  - HALF[i] = CLOCK_FREQ_HZ/(2*f) (integer division), computed at elaboration.
- Melody ROM entries are (pitch, duration ticks):
  - LOADING: (1,2)(3,2)(5,2)(0,2), loops.
  - READY: (5,4)(6,4)(8,8)(0,1), one-shot.
  - GAME_PLAY: (1,1)(0,1)(5,1)(0,1), loops.
  - FAIL: (8,4)(6,4)(4,4)(1,8), one-shot.
  - WIN: (1,2)(3,2)(5,2)(8,8), one-shot.
  - Any other sound_type encoding: silent, treated as a finished one-shot.
- FSM states: IDLE, START, PLAY, DONE.
  - IDLE: entered on reset.
  - START: load note index 0, reload tone and duration counters, clear square. Lasts 1 cycle.
  - PLAY: runs the current note.
  - DONE: audio_pwm=0, audio_sd=0, busy=0.
- Change detect: sound_type is registered every cycle into `cur_type`. If sound_type != cur_type, or state==IDLE, the next state is START, from any state.
  - Restart latency: the first note's square begins 2 cycles after sound_type changes.
- Tone counter:
  - Reloads HALF[p]-1; decrements each cycle; at 0 it toggles `sq` and reloads.
  - For a rest (p=0), sq is held at 0.
  - audio_pwm = sq in PLAY, else 0.
- Duration: a tick prescaler (0..TICK_CLKS-1) plus a tick counter.
  - When the tick counter reaches the note's duration, advance the note index. Each note lasts exactly dur*TICK_CLKS cycles.
  - On note advance, sq clears and the tone counter reloads.
  - After index 3: looping sounds wrap to index 0 with no gap; one-shots go to DONE.
- busy=1 and audio_sd=1 in START and PLAY.
- Reset values: state=IDLE; audio_pwm=0, audio_sd=0, busy=0; all counters 0; cur_type=SOUND_LOADING.
- Reset asserted mid-note: outputs are 0 the next cycle, and the melody restarts from note 0 after rst deasserts.
- Simultaneous events: a sound_type change takes priority over a note advance or wrap in the same cycle.

Optional Feature:
- Macro: PACMAN_SOUND_VOLUME_EN.
- Enabled:
  - Adds input `volume` [2:0] and a free-running 3-bit pwm counter.
  - audio_pwm = sq && (pwm_cnt < volume). volume=0 gives silence; volume=7 gives 7/8 duty while sq is high.
- Disabled: the port is absent and audio_pwm = sq.

Test Plan (all scenarios use CLOCK_FREQ_HZ=1_000_000, TICK_MS=1, so TICK_CLKS=1000; C5 half=956, E5=758, G5=637, C6=477):
- LOADING after rst:
  - First audio_pwm rising edge occurs 2 cycles after rst deasserts.
  - Edges are then 956 cycles apart for 2000 cycles, then 758-cycle half periods.
  - After 8000 cycles the melody loops to C5; busy stays 1.
- READY one-shot: stepping 5 -> 6 -> 8 -> rest, busy falls exactly 17000 cycles after START, and audio_pwm and audio_sd read 0 thereafter.
- Switch WIN -> FAIL mid-note 1: the melody restarts at C6 (half period 477) 2 cycles after the change, with no leftover E5 edge.
- GAME_PLAY: audio_pwm is 0 throughout cycles 1000-1999 (rest), and G5 edges 637 cycles apart appear in 2000-2999.
- rst pulsed for 1 cycle during the FAIL note 3:
  - All outputs are 0 the next cycle.
  - FAIL restarts from C6 once rst deasserts.
- Volume (PACMAN_SOUND_VOLUME_EN defined):
  - volume=0: audio_pwm is constant 0 while busy=1.
  - volume=4: 4 of every 8 cycles are high while sq=1.
